pulse_count_fsm: RTL and testbench

//   Multi-channel pulse-counting state machine. Each channel counts rising edges of its own

---
 rtl/pulse_count_fsm.sv | 112 +++++++++++
 tb/tb_pulse_count_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_count_fsm.sv
// Multi-channel pulse counter: synchronised rising edges on a[i] step a per-channel count
// toward STEPS, with optional wrap and optional inactivity timeout back to zero.
module pulse_count_fsm #(
   parameter int CH          = 1,
   parameter int STEPS       = 4,
   parameter int WRAP        = 0,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 0,
   localparam int SW         = $clog2(STEPS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CH-1:0]    a,
   input  logic             clr,
   output logic [CH*SW-1:0] state,
   output logic [CH-1:0]    on,
   output logic [CH-1:0]    hit,
   output logic             all_on
);

   localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [SW-1:0] ST_ZERO = '0;
   localparam logic [SW-1:0] ST_LAST = SW'(STEPS - 1);
   localparam logic [SW-1:0] ST_FULL = SW'(STEPS);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

   logic [CH-1:0] sync_q [SYNC_STAGES];
   logic [CH-1:0] prev_q;
   logic [CH-1:0] rise;

   logic [SW-1:0] count_q [CH];
   logic [SW-1:0] count_d [CH];
   logic [IW-1:0] idle_q [CH];
   logic [IW-1:0] idle_d [CH];
   logic [CH-1:0] hit_q;
   logic [CH-1:0] hit_d;

   // The sync chain and prev flop ignore clr so that clearing never fakes an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= a;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

   always_comb begin
      hit_d = '0;
      for (int i = 0; i < CH; i++) begin
         count_d[i] = count_q[i];
         idle_d[i]  = idle_q[i];
         if (clr) begin
            count_d[i] = ST_ZERO;
            idle_d[i]  = '0;
         end else if (rise[i]) begin
            idle_d[i] = '0;
            if (count_q[i] == ST_FULL) begin
               count_d[i] = (WRAP != 0) ? ST_ZERO : ST_FULL;
            end else begin
               count_d[i] = count_q[i] + 1'b1;
            end
            hit_d[i] = (count_q[i] == ST_LAST);
         end else if (TIMEOUT > 0) begin
            if (count_q[i] == ST_ZERO) begin
               idle_d[i] = '0;
            end else if (idle_q[i] == IDLE_LAST) begin
               count_d[i] = ST_ZERO;
               idle_d[i]  = '0;
            end else begin
               idle_d[i] = idle_q[i] + 1'b1;
            end
         end else begin
            idle_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            count_q[i] <= ST_ZERO;
            idle_q[i]  <= '0;
         end
         hit_q <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            count_q[i] <= count_d[i];
            idle_q[i]  <= idle_d[i];
         end
         hit_q <= hit_d;
      end
   end

   always_comb begin
      state = '0;
      on    = '0;
      for (int i = 0; i < CH; i++) begin
         state[i*SW +: SW] = count_q[i];
         on[i]             = (count_q[i] == ST_FULL);
      end
   end

   assign hit    = hit_q;
   assign all_on = &on;

endmodule

// File: tb/tb_pulse_count_fsm.sv
// Scoreboard bench: stimulus queues expected output vectors, a monitor pops one per observed
// output change and checks value and, where given, the cycle distance from the previous change.
module tb_pulse_count_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] rst;
   logic       clr0;
   logic       a0, a1, a2;
   logic [2:0] a3;

   logic [2:0] s0, s1, s2;
   logic       on0, on1, on2, hit0, hit1, hit2, all0, all1, all2;
   logic [8:0] s3;
   logic [2:0] on3, hit3;
   logic       all3;

   pulse_count_fsm #(.CH(1), .STEPS(4), .WRAP(0), .SYNC_STAGES(2), .TIMEOUT(0)) u_d0 (
      .clk(clk), .rst(rst[0]), .a(a0), .clr(clr0),
      .state(s0), .on(on0), .hit(hit0), .all_on(all0));
   pulse_count_fsm #(.CH(1), .STEPS(4), .WRAP(1), .SYNC_STAGES(2), .TIMEOUT(0)) u_d1 (
      .clk(clk), .rst(rst[1]), .a(a1), .clr(1'b0),
      .state(s1), .on(on1), .hit(hit1), .all_on(all1));
   pulse_count_fsm #(.CH(1), .STEPS(4), .WRAP(0), .SYNC_STAGES(2), .TIMEOUT(8)) u_d2 (
      .clk(clk), .rst(rst[2]), .a(a2), .clr(1'b0),
      .state(s2), .on(on2), .hit(hit2), .all_on(all2));
   pulse_count_fsm #(.CH(3), .STEPS(4), .WRAP(0), .SYNC_STAGES(2), .TIMEOUT(0)) u_d3 (
      .clk(clk), .rst(rst[3]), .a(a3), .clr(1'b0),
      .state(s3), .on(on3), .hit(hit3), .all_on(all3));

   logic [33:0] obs;
   assign obs = {all3, hit3, on3, s3, all2, hit2, on2, s2,
                 all1, hit1, on1, s1, all0, hit0, on0, s0};

   typedef struct packed {
      int          dly;
      logic [33:0] v;
   } exp_t;

   exp_t        q[$];
   logic [33:0] m;
   int          tests = 0;
   int          fails = 0;

   task automatic push(input int dly);
      exp_t e;
      e.dly = dly;
      e.v   = m;
      q.push_back(e);
   endtask

   // Field order per single-channel DUT: {all_on, hit, on, state}
   task automatic set1(input int id, input logic [2:0] s, input logic h);
      logic o;
      o = (s == 3'd4);
      m[id*6 +: 6] = {o, h, o, s};
   endtask

   task automatic set3(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                       input logic [2:0] h);
      logic [2:0] o;
      o = {c2 == 3'd4, c1 == 3'd4, c0 == 3'd4};
      m[33:18] = {&o, h, o, c2, c1, c0};
   endtask

   task automatic drive(input int id, input logic [2:0] v);
      case (id)
         0:       a0 = v[0];
         1:       a1 = v[0];
         2:       a2 = v[0];
         default: a3 = v;
      endcase
   endtask

   // High for two clocks, low for two; with clr_edge, clr coincides with the detected edge.
   task automatic pulse(input int id, input logic [2:0] v, input bit clr_edge);
      @(posedge clk); #1 drive(id, v);
      @(posedge clk);
      @(posedge clk); #1 drive(id, 3'b000);
      if (clr_edge) clr0 = 1'b1;
      @(posedge clk); #1 clr0 = 1'b0;
      @(posedge clk);
   endtask

   // Monitor
   initial begin
      logic [33:0] prev;
      exp_t        e;
      int          cyc;
      int          last;
      prev = '1;
      cyc  = 0;
      last = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (obs !== prev) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, obs);
            end else begin
               e = q.pop_front();
               if (obs !== e.v || (e.dly >= 0 && cyc - last != e.dly)) begin
                  fails++;
                  $display("FAIL output_change cyc=%0d got=%h after %0d required=%h after %0d",
                           cyc, obs, cyc - last, e.v, e.dly);
               end
            end
            last = cyc;
            prev = obs;
         end
      end
   end

   initial begin
      int         c [3];
      logic [2:0] h;
      logic [2:0] vec [7];
      exp_t       e;
      vec = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b111, 3'b011, 3'b100};

      rst  = 4'hF;
      clr0 = 1'b0;
      a0 = 1'b0; a1 = 1'b0; a2 = 1'b0; a3 = 3'b000;
      m = '0;
      push(-1);
      repeat (3) @(posedge clk);
      #1 rst = 4'h0;

      // Saturating count of five pulses
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) begin
            set1(0, 3'(k), k == 4);
            push(-1);
            if (k == 4) begin
               set1(0, 3'd4, 1'b0);
               push(1);
            end
         end
         pulse(0, 3'b001, 1'b0);
      end

      // clr alone, then clr colliding with the edge at count 3
      set1(0, 3'd0, 1'b0);
      push(-1);
      @(posedge clk); #1 clr0 = 1'b1;
      @(posedge clk); #1 clr0 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         set1(0, 3'(k), 1'b0);
         push(-1);
         pulse(0, 3'b001, 1'b0);
      end
      set1(0, 3'd0, 1'b0);
      push(-1);
      pulse(0, 3'b001, 1'b1);
      set1(0, 3'd1, 1'b0);
      push(-1);
      pulse(0, 3'b001, 1'b0);

      // rst at count 2 with a held high
      set1(0, 3'd2, 1'b0);
      push(-1);
      pulse(0, 3'b001, 1'b0);
      set1(0, 3'd0, 1'b0);
      push(-1);
      set1(0, 3'd1, 1'b0);
      push(4);
      @(posedge clk); #1 a0 = 1'b1; rst[0] = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 rst[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1 a0 = 1'b0;
      repeat (4) @(posedge clk);

      // Wrapping channel, nine pulses
      for (int k = 1; k <= 9; k++) begin
         set1(1, 3'(k % 5), (k % 5) == 4);
         push(-1);
         if (k % 5 == 4) begin
            set1(1, 3'd4, 1'b0);
            push(1);
         end
         pulse(1, 3'b001, 1'b0);
      end

      // Timeout drop, then an edge on the timeout clock
      for (int r = 0; r < 2; r++) begin
         set1(2, 3'd1, 1'b0); push(-1);
         pulse(2, 3'b001, 1'b0);
         set1(2, 3'd2, 1'b0); push(-1);
         pulse(2, 3'b001, 1'b0);
         if (r == 0) begin
            set1(2, 3'd0, 1'b0); push(8);
            repeat (12) @(posedge clk);
         end else begin
            repeat (3) @(posedge clk);
            set1(2, 3'd3, 1'b0); push(8);
            pulse(2, 3'b001, 1'b0);
            set1(2, 3'd0, 1'b0); push(8);
            repeat (12) @(posedge clk);
         end
      end

      // Three channels, interleaved and simultaneous pulses
      c = '{0, 0, 0};
      for (int p = 0; p < 7; p++) begin
         h = '0;
         for (int j = 0; j < 3; j++) begin
            if (vec[p][j] && c[j] < 4) begin
               c[j]++;
               h[j] = (c[j] == 4);
            end
         end
         set3(3'(c[0]), 3'(c[1]), 3'(c[2]), h);
         push(-1);
         if (h != 3'b000) begin
            set3(3'(c[0]), 3'(c[1]), 3'(c[2]), 3'b000);
            push(1);
         end
         pulse(3, vec[p], 1'b0);
      end

      repeat (6) @(posedge clk);
      while (q.size() > 0) begin
         e = q.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_change got=none required=%h", e.v);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
